multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32 core. It sequences fetch, decode, execute, memory access and writeback for R-type, lw, sw and beq.
- Drives the 2-bit ALUOp consumed by the ALU control decoder, plus mux selects and write enables for the shared ALU/memory datapath.
- Handles a mem_ready handshake with memory. Traps on illegal opcodes and on memory timeouts.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for mem_ready in any memory state before bus-error trap (>=1)
TO_W, 5, timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
opcode  in  7  instr[6:0] from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
PCWrite  out  1  PC load enable (unconditional)
Branch  out  1  conditional PC load; PC loads when Branch & zero
IRWrite  out  1  instruction register load
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
RegWrite  out  1  register file write
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
ALUSrcB  out  2  00=rs2, 01=imm, 10=constant 4
ALUOp  out  2  00=add, 01=sub (branch), 10=funct-decoded
ResultSrc  out  2  00=ALUOut, 01=mem data, 10=ALU result
instr_retired  out  1  one-cycle pulse when an instruction completes
illegal_instr  out  1  sticky: trap on illegal opcode
bus_error  out  1  sticky: trap on memory timeout
state_dbg  out  4  current state encoding

Behaviour:
Outputs and reset:
- All outputs except the sticky flags and state_dbg are Moore decodes of the state register.
- While reset=0, every output is forced to 0.
- On a clk edge with reset=0: state<=FETCH, timeout counter<=0, illegal_instr<=0, bus_error<=0.
- Reset sampled low mid-instruction aborts it. No write enable may be asserted in the cycle after that edge.

States (encoding 0-9) and actions (unlisted outputs are 0):
- FETCH(0): MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite assert only in the cycle mem_ready=1. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXECUTE
  - 0000011 or 0100011 -> MEMADR
  - 1100011 -> BRANCH
  - any other -> TRAP, setting illegal_instr.
- MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD, sw -> MEMWRITE. The opcode is held in IR; IRWrite is low.
- MEMREAD(3): MemRead=1, AdrSrc=1. Wait for mem_ready -> MEMWB.
- MEMWB(4): RegWrite=1, ResultSrc=01, instr_retired=1 -> FETCH.
- MEMWRITE(5): MemWrite=1, AdrSrc=1. On mem_ready, instr_retired=1 -> FETCH.
- EXECUTE(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB(7): RegWrite=1, ResultSrc=00, instr_retired=1 -> FETCH.
- BRANCH(8): ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1, ResultSrc=00, instr_retired=1 -> FETCH, whether taken or not.
- TRAP(9): all enables 0. Remains until reset.

Latency (zero-wait memory, mem_ready high on first request cycle):
- R-type 4 cycles, lw 5, sw 4, beq 3.
- Each memory wait cycle adds 1.

Timeout counter:
- Increments on each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
- Clears on mem_ready=1 and on any state change.
- When the counter reaches MEM_TIMEOUT with mem_ready still 0, next state is TRAP and bus_error is set.
- mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT counts as success; no trap.

Other rules:
- mem_ready is ignored outside memory states.
- Sticky flags clear only on reset.

Test Plan:
- Reset held low 3 cycles, then released with mem_ready=1 and opcode=0110011 -> all enables 0 during reset; states 0,1,6,7,0. ALUOp=10 only in state 6. RegWrite=1 and instr_retired=1 only in state 7.
- lw (0000011) with mem_ready=1 on FETCH, low 2 cycles in MEMREAD, then high -> states 0,1,2,3,3,3,4. MemRead and AdrSrc=1 throughout state 3. RegWrite with ResultSrc=01 in state 4. Total 7 cycles.
- beq (1100011), zero=1 then repeated with zero=0 -> 3 cycles each. Branch=1 and ALUOp=01 in state 8. PCWrite=0 in state 8 both times. instr_retired pulses once per instruction.
- sw (0100011) -> MemWrite=1 only in state 5. RegWrite never asserted. Returns to FETCH after 4 cycles.
- Opcode 1111111 -> TRAP after DECODE. illegal_instr=1 and stays in TRAP for 20 cycles. Reset low for 1 edge -> FETCH, illegal_instr=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles with bus_error=1. Second run with mem_ready=1 on exactly the 4th wait cycle -> no trap; proceeds to DECODE.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multi-cycle RV32 core
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state_dbg
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        TRAP     = 4'd9
    } state_t;

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            ill_q;
    logic            be_q;
    logic            mem_state;
    logic            timed_out;
    logic            unused_zero;

    // zero is consumed by the datapath's PC-load gate, not by the sequencer
    assign unused_zero = zero;

    assign mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    // the last permitted wait cycle still succeeds if mem_ready arrives in it
    assign timed_out = mem_state && !mem_ready && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= FETCH;
            to_cnt <= '0;
            ill_q  <= 1'b0;
            be_q   <= 1'b0;
        end else begin
            if (mem_state && !mem_ready && !timed_out) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    if (opcode == OP_R) begin
                        state <= EXECUTE;
                    end else if (opcode == OP_LW || opcode == OP_SW) begin
                        state <= MEMADR;
                    end else if (opcode == OP_BEQ) begin
                        state <= BRANCH;
                    end else begin
                        state <= TRAP;
                        ill_q <= 1'b1;
                    end
                end
                MEMADR:   state <= (opcode == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (mem_ready) state <= FETCH;
                EXECUTE:  state <= ALUWB;
                ALUWB:    state <= FETCH;
                BRANCH:   state <= FETCH;
                default:  state <= TRAP;
            endcase
            if (timed_out) begin
                state <= TRAP;
                be_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        PCWrite       = 1'b0;
        Branch        = 1'b0;
        IRWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        ResultSrc     = 2'b00;
        instr_retired = 1'b0;
        case (state)
            FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                RegWrite      = 1'b1;
                ResultSrc     = 2'b01;
                instr_retired = 1'b1;
            end
            MEMWRITE: begin
                MemWrite      = 1'b1;
                AdrSrc        = 1'b1;
                instr_retired = mem_ready;
            end
            EXECUTE: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            BRANCH: begin
                ALUSrcA       = 2'b10;
                ALUOp         = 2'b01;
                Branch        = 1'b1;
                instr_retired = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            PCWrite       = 1'b0;
            Branch        = 1'b0;
            IRWrite       = 1'b0;
            AdrSrc        = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            RegWrite      = 1'b0;
            ALUSrcA       = 2'b00;
            ALUSrcB       = 2'b00;
            ALUOp         = 2'b00;
            ResultSrc     = 2'b00;
            instr_retired = 1'b0;
        end
    end

    assign illegal_instr = reset & ill_q;
    assign bus_error     = reset & be_q;
    assign state_dbg     = reset ? state : 4'd0;
endmodule
